// File: rtl/maxpool2x2_stream_pkg.sv
// Shared types and frame constants for the 2x2 max-pool stage and the FC stage behind it.
// The FC stage derives its beat count from OUT_PIX.
package maxpool2x2_stream_pkg;

    localparam int DFLT_DATA_BITS   = 8;
    localparam int DFLT_CHANNEL_LEN = 3;
    localparam int DFLT_IN_W        = 8;
    localparam int DFLT_IN_H        = 8;

    localparam int OUT_PIX   = DFLT_IN_W * DFLT_IN_H / 4;
    localparam int OUT_IDX_W = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;

    typedef logic signed [DFLT_DATA_BITS-1:0] sample_t;
    typedef sample_t [DFLT_CHANNEL_LEN-1:0]   beat_t;

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream in, pooled stream out. The slave side is the pooler and the master side is the producer/consumer.
// There is no backpressure in either direction.
interface maxpool2x2_stream_if
    import maxpool2x2_stream_pkg::*;
#(
    parameter int DATA_BITS   = DFLT_DATA_BITS,
    parameter int CHANNEL_LEN = DFLT_CHANNEL_LEN,
    parameter int IN_W        = DFLT_IN_W,
    parameter int IN_H        = DFLT_IN_H
);
    localparam int NPIX  = IN_W * IN_H / 4;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    logic                              in_val;
    logic [CHANNEL_LEN*DATA_BITS-1:0]  data_in;
    logic                              out_val;
    logic [CHANNEL_LEN*DATA_BITS-1:0]  data_out;
    logic [IDX_W-1:0]                  out_idx;
    logic                              frame_done;

    modport slave  (input in_val, data_in, output out_val, data_out, out_idx, frame_done);
    modport master (output in_val, data_in, input out_val, data_out, out_idx, frame_done);

endinterface

// File: rtl/maxpool2x2_stream_smax2.sv
// Signed maximum of two samples.
// This block is purely combinational, with no latency and no backpressure.
module smax2
    import maxpool2x2_stream_pkg::*;
#(
    parameter int DATA_BITS = DFLT_DATA_BITS
) (
    input  logic signed [DATA_BITS-1:0] a,
    input  logic signed [DATA_BITS-1:0] b,
    output logic signed [DATA_BITS-1:0] y
);

    assign y = (a > b) ? a : b;

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 signed max-pool over a raster pixel stream, one pooled beat per window.
// Latency: 1 cycle from the bottom-right pixel of a window to out_val.
// Backpressure: none. Gaps on in_val freeze all state.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int DATA_BITS   = DFLT_DATA_BITS,
    parameter int CHANNEL_LEN = DFLT_CHANNEL_LEN,
    parameter int IN_W        = DFLT_IN_W,
    parameter int IN_H        = DFLT_IN_H
) (
    input  logic                 clk,
    input  logic                 rst,
    maxpool2x2_stream_if.slave   bus
);

    localparam int BW    = CHANNEL_LEN * DATA_BITS;
    localparam int NPIX  = IN_W * IN_H / 4;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int COL_W = $clog2(IN_W);
    localparam int ROW_W = $clog2(IN_H);
    localparam int LB_D  = IN_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [IDX_W-1:0] out_cnt;
    logic [LB_AW-1:0] lb_addr;

    logic [BW-1:0]    hold;
    logic [BW-1:0]    linebuf [LB_D];
    logic [BW-1:0]    lb_rd;
    logic [BW-1:0]    h_max;
    logic [BW-1:0]    v_max;

    logic             out_val_q;
    logic             frame_done_q;
    logic [BW-1:0]    data_out_q;
    logic [IDX_W-1:0] out_idx_q;

    assign lb_addr = LB_AW'(col >> 1);
    assign lb_rd   = linebuf[lb_addr];

    // Horizontal max feeds both the line buffer write and the vertical stage.
    for (genvar c = 0; c < CHANNEL_LEN; c++) begin : g_ch
        logic signed [DATA_BITS-1:0] din_c;
        logic signed [DATA_BITS-1:0] hold_c;
        logic signed [DATA_BITS-1:0] lb_c;
        logic signed [DATA_BITS-1:0] hmax_c;
        logic signed [DATA_BITS-1:0] vmax_c;

        assign din_c  = bus.data_in[c*DATA_BITS +: DATA_BITS];
        assign hold_c = hold[c*DATA_BITS +: DATA_BITS];
        assign lb_c   = lb_rd[c*DATA_BITS +: DATA_BITS];

        smax2 #(.DATA_BITS(DATA_BITS)) u_hmax (.a(hold_c), .b(din_c),  .y(hmax_c));
        smax2 #(.DATA_BITS(DATA_BITS)) u_vmax (.a(lb_c),   .b(hmax_c), .y(vmax_c));

        assign h_max[c*DATA_BITS +: DATA_BITS] = hmax_c;
        assign v_max[c*DATA_BITS +: DATA_BITS] = vmax_c;
    end

    // Datapath storage is always written before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && bus.in_val) begin
            if (!col[0]) begin
                hold <= bus.data_in;
            end else if (!row[0]) begin
                linebuf[lb_addr] <= h_max;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            out_cnt      <= '0;
            out_val_q    <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
            out_idx_q    <= '0;
        end else begin
            out_val_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.in_val) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (col[0] && row[0]) begin
                    data_out_q   <= v_max;
                    out_val_q    <= 1'b1;
                    out_idx_q    <= out_cnt;
                    frame_done_q <= (out_cnt == IDX_LAST);
                    out_cnt      <= (out_cnt == IDX_LAST) ? '0 : out_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_val    = out_val_q;
    assign bus.frame_done = frame_done_q;
    assign bus.data_out   = data_out_q;
    assign bus.out_idx    = out_idx_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: ramp, signed, gapped, back-to-back, mid-frame reset and per-channel frames.
module tb_maxpool2x2_stream;
    import maxpool2x2_stream_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool2x2_stream_if bus ();
    maxpool2x2_stream dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [23:0] d;
        logic [3:0]  i;
        logic        f;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Window maxima of the ramp frame (pixel = row*8+col), in raster order.
    int ramp_tbl [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] pack3(input int c0, input int c1, input int c2);
        beat_t b;
        b[0] = 8'(c0);
        b[1] = 8'(c1);
        b[2] = 8'(c2);
        return b;
    endfunction

    task automatic push_exp(input logic [23:0] d, input int i);
        exp_t e;
        e.d = d;
        e.i = 4'(i);
        e.f = (i == OUT_PIX - 1);
        exp_q.push_back(e);
    endtask

    // Position tracker: an output is due the cycle after an accepted bottom-right pixel.
    int   m_col = 0;
    int   m_row = 0;
    logic exp_ov = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_col = 0; m_row = 0; exp_ov = 1'b0;
        end else if (bus.in_val) begin
            exp_ov = (m_col % 2 == 1) && (m_row % 2 == 1);
            if (m_col == 7) begin
                m_col = 0;
                m_row = (m_row == 7) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end else begin
            exp_ov = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_val || exp_ov) chk("out_val", 32'(bus.out_val), 32'(exp_ov));
            if (bus.frame_done && !bus.out_val) chk("fd_stray", 32'(bus.frame_done), 0);
            if (bus.out_val) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data_out",   32'(bus.data_out),   32'(e.d));
                    chk("out_idx",    32'(bus.out_idx),    32'(e.i));
                    chk("frame_done", 32'(bus.frame_done), 32'(e.f));
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [23:0] d);
        bus.data_in = d;
        bus.in_val  = 1'b1;
        @(posedge clk); #1;
        bus.in_val  = 1'b0;
    endtask

    task automatic ramp_frame(input bit neg, input bit gaps, input int npix);
        int v;
        for (int p = 0; p < npix; p++) begin
            v = neg ? -p : p;
            if (gaps) while ($urandom_range(1) == 1) idle();
            drive(pack3(v, v, v));
        end
    endtask

    task automatic push_ramp(input bit neg, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = neg ? -(ramp_tbl[i] - 9) : ramp_tbl[i];
            push_exp(pack3(t, t, t), i);
        end
    endtask

    task automatic drain(input string tag);
        repeat (3) idle();
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_val  = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_val",    32'(bus.out_val), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_data_out",   32'(bus.data_out), 0);
        chk("rst_out_idx",    32'(bus.out_idx), 0);

        // Continuous ramp frame.
        push_ramp(1'b0, 16);
        ramp_frame(1'b0, 1'b0, 64);
        drain("ramp_pending");
        chk("data_out_hold", 32'(bus.data_out), 32'(pack3(63, 63, 63)));

        // Signed frame: -100 everywhere, ch0 (1,1) = -3, ch2 all -128.
        push_exp(pack3(-3, -100, -128), 0);
        for (int i = 1; i < 16; i++) push_exp(pack3(-100, -100, -128), i);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                drive(pack3((r == 1 && c == 1) ? -3 : -100, -100, -128));
        drain("neg_pending");

        // Ramp frame with random gaps.
        push_ramp(1'b0, 16);
        ramp_frame(1'b0, 1'b1, 64);
        drain("gap_pending");

        // Ramp then negated ramp with no bubble between them.
        push_ramp(1'b0, 16);
        push_ramp(1'b1, 16);
        ramp_frame(1'b0, 1'b0, 64);
        ramp_frame(1'b1, 1'b0, 64);
        drain("b2b_pending");

        // Mid-frame reset after 37 pixels. A beat is offered during reset and must be ignored.
        push_ramp(1'b0, 8);
        ramp_frame(1'b0, 1'b0, 37);
        rst = 1'b1;
        bus.in_val = 1'b1;
        bus.data_in = pack3(99, 99, 99);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_val = 1'b0;
        chk("mrst_out_val", 32'(bus.out_val), 0);
        chk("mrst_out_idx", 32'(bus.out_idx), 0);
        chk("mrst_pending", 32'(exp_q.size()), 0);
        push_ramp(1'b0, 16);
        ramp_frame(1'b0, 1'b0, 64);
        drain("mrst_frame_pending");

        // Per-channel maxima: ch0 at (0,0), ch1 at (0,1), ch2 at (1,0) of each window.
        for (int i = 0; i < 16; i++) push_exp(pack3(40 + i, 50 + i, 60 + i), i);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                int w;
                int v0, v1, v2;
                w  = (r / 2) * 4 + c / 2;
                v0 = w; v1 = w; v2 = w;
                if (r % 2 == 0 && c % 2 == 0) v0 = 40 + w;
                if (r % 2 == 0 && c % 2 == 1) v1 = 50 + w;
                if (r % 2 == 1 && c % 2 == 0) v2 = 60 + w;
                if (r % 2 == 1 && c % 2 == 1) begin
                    v0 = w - 20; v1 = w - 20; v2 = w - 20;
                end
                drive(pack3(v0, v1, v2));
            end
        drain("chan_pending");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
